// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
// Pure definitions; no logic, no latency, no flow control.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Bits needed to hold 0..v-1; returns 0 for v<=1, callers floor to 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
// Plain wires; no latency, no backpressure.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);
    import counter_pkg::*;

    logic             cnt_en;
    logic             pause;
    logic             dir;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] cnt_data;
    logic             tc;
    logic             done;

    modport master (
        output cnt_en, pause, dir, sat_mode, load, load_data,
        input  cnt_data, tc, done
    );

    modport slave (
        input  cnt_en, pause, dir, sat_mode, load, load_data,
        output cnt_data, tc, done
    );
endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE into a one-cycle tick; clr wins over en.
// tick is combinational from pre_cnt and en; no backpressure.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;

    assign tick = en && !clr && (pre_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mod_updown_counter.sv
// Prescaled up/down counter with load, wrap/saturate, registered tc and sticky done.
// Count updates on the tick edge, tc coincides with the wrapped value; no backpressure.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic             tc_q;
    logic             done_q;
    logic             tick;
    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] load_val;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.load | ~bus.cnt_en),
        .en    (bus.cnt_en & ~bus.pause),
        .tick  (tick)
    );

    assign bound    = (bus.dir == DIR_UP) ? MAX : '0;
    assign load_val = (bus.load_data > MAX) ? MAX : bus.load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.load) begin
            cnt_q  <= load_val;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (!bus.cnt_en) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (tick && !done_q) begin
            // Below the bound the step cannot overflow, so no modular arithmetic is relied on.
            if (cnt_q != bound) begin
                cnt_q <= (bus.dir == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
                tc_q  <= 1'b0;
            end else if (bus.sat_mode == MODE_WRAP) begin
                cnt_q <= (bus.dir == DIR_UP) ? '0 : MAX;
                tc_q  <= 1'b1;
            end else begin
                done_q <= 1'b1;
                tc_q   <= 1'b1;
            end
        end else begin
            // Paused, between ticks, or halted by done: hold count, drop tc.
            tc_q <= 1'b0;
        end
    end

    assign bus.cnt_data = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench over three counter configurations: 8-bit default, mod-10, mod-10 with /4 prescaler.
module tb_mod_updown_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mod_updown_counter_if #(.WIDTH(8)) a_if ();
    mod_updown_counter_if #(.WIDTH(4)) b_if ();
    mod_updown_counter_if #(.WIDTH(4)) c_if ();

    mod_updown_counter #(.WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input int c, input int t, input int d);
        check({tag, ".cnt"}, int'(a_if.cnt_data), c);
        check({tag, ".tc"}, int'(a_if.tc), t);
        check({tag, ".done"}, int'(a_if.done), d);
    endtask

    task automatic chk_b(input string tag, input int c, input int t, input int d);
        check({tag, ".cnt"}, int'(b_if.cnt_data), c);
        check({tag, ".tc"}, int'(b_if.tc), t);
        check({tag, ".done"}, int'(b_if.done), d);
    endtask

    task automatic chk_c(input string tag, input int c, input int t, input int d);
        check({tag, ".cnt"}, int'(c_if.cnt_data), c);
        check({tag, ".tc"}, int'(c_if.tc), t);
        check({tag, ".done"}, int'(c_if.done), d);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_if.cnt_en, a_if.pause, a_if.dir, a_if.sat_mode, a_if.load} = '0;
        {b_if.cnt_en, b_if.pause, b_if.dir, b_if.sat_mode, b_if.load} = '0;
        {c_if.cnt_en, c_if.pause, c_if.dir, c_if.sat_mode, c_if.load} = '0;
        a_if.load_data = '0;
        b_if.load_data = '0;
        c_if.load_data = '0;

        #50;
        chk_a("rst_a", 0, 0, 0);
        chk_b("rst_b", 0, 0, 0);
        chk_c("rst_c", 0, 0, 0);
        #50;
        rst_n = 1'b1;

        // 8-bit free run: 0..255 then wrap with a single tc pulse
        a_if.cnt_en = 1'b1;
        a_if.dir    = DIR_UP;
        for (int i = 1; i <= 258; i++) begin
            step();
            check("a_run.cnt", int'(a_if.cnt_data), i % 256);
            check("a_run.tc", int'(a_if.tc), (i == 256) ? 1 : 0);
        end
        a_if.cnt_en = 1'b0;

        // Mod-10 up with wrap, then reverse at 3 and wrap downward to 9
        b_if.cnt_en = 1'b1;
        b_if.dir    = DIR_UP;
        for (int i = 1; i <= 13; i++) begin
            step();
            chk_b("b_up", i % 10, (i == 10) ? 1 : 0, 0);
        end
        b_if.dir = DIR_DOWN;
        step(); chk_b("b_dn2", 2, 0, 0);
        step(); chk_b("b_dn1", 1, 0, 0);
        step(); chk_b("b_dn0", 0, 0, 0);
        step(); chk_b("b_dn_wrap", 9, 1, 0);
        step(); chk_b("b_dn8", 8, 0, 0);

        // Prescale /4 with a 3-cycle pause mid-period
        c_if.cnt_en = 1'b1;
        c_if.dir    = DIR_UP;
        step(); chk_c("c_e1", 0, 0, 0);
        step(); chk_c("c_e2", 0, 0, 0);
        step(); chk_c("c_e3", 0, 0, 0);
        step(); chk_c("c_e4", 1, 0, 0);
        step(); chk_c("c_e5", 1, 0, 0);
        step(); chk_c("c_e6", 1, 0, 0);
        c_if.pause = 1'b1;
        step(); chk_c("c_p7", 1, 0, 0);
        step(); chk_c("c_p8", 1, 0, 0);
        step(); chk_c("c_p9", 1, 0, 0);
        c_if.pause = 1'b0;
        step(); chk_c("c_e10", 1, 0, 0);
        step(); chk_c("c_e11", 2, 0, 0);

        // Saturate: hold at 9 with done, immune to mode/dir changes until load
        b_if.sat_mode  = MODE_SAT;
        b_if.dir       = DIR_UP;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd0;
        step(); chk_b("s_ld0", 0, 0, 0);
        b_if.load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk_b("s_up", i, 0, 0);
        end
        step(); chk_b("s_hit", 9, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_b("s_hold", 9, 0, 1);
        end
        b_if.sat_mode = MODE_WRAP;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b("s_wrapmode_hold", 9, 0, 1);
        end
        b_if.dir = DIR_DOWN;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b("s_dirdown_hold", 9, 0, 1);
        end
        b_if.dir       = DIR_UP;
        b_if.sat_mode  = MODE_SAT;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd5;
        step(); chk_b("s_ld5", 5, 0, 0);
        b_if.load = 1'b0;
        step(); chk_b("s_r6", 6, 0, 0);
        step(); chk_b("s_r7", 7, 0, 0);

        // Load priority and clamp
        b_if.cnt_en    = 1'b0;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd12;
        step(); chk_b("l_clamp", 9, 0, 0);
        b_if.load = 1'b0;
        step(); chk_b("l_dis", 0, 0, 0);
        b_if.cnt_en    = 1'b1;
        b_if.pause     = 1'b1;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd4;
        step(); chk_b("l_pause_ld", 4, 0, 0);
        b_if.load = 1'b0;
        step(); chk_b("l_pause_hold", 4, 0, 0);
        b_if.pause     = 1'b0;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd8;
        step(); chk_b("l_ld8", 8, 0, 0);
        b_if.load = 1'b0;
        step(); chk_b("l_9", 9, 0, 0);
        step(); chk_b("l_done", 9, 1, 1);
        b_if.cnt_en = 1'b0;
        step(); chk_b("l_en_clr", 0, 0, 0);

        // Async reset mid-count, with dut_a holding done=1 at the same time
        b_if.cnt_en    = 1'b1;
        b_if.sat_mode  = MODE_WRAP;
        b_if.dir       = DIR_UP;
        b_if.load      = 1'b1;
        b_if.load_data = 4'd6;
        a_if.cnt_en    = 1'b1;
        a_if.sat_mode  = MODE_SAT;
        a_if.dir       = DIR_UP;
        a_if.load      = 1'b1;
        a_if.load_data = 8'd255;
        step(); chk_b("r_ld6", 6, 0, 0);
        b_if.load = 1'b0;
        a_if.load = 1'b0;
        step();
        chk_b("r_pre_b", 7, 0, 0);
        chk_a("r_pre_a", 255, 1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_b("r_async_b", 0, 0, 0);
        chk_a("r_async_a", 0, 0, 0);
        step();
        chk_b("r_held_b", 0, 0, 0);
        chk_a("r_held_a", 0, 0, 0);
        #3;
        rst_n = 1'b1;
        #1;
        chk_b("r_rel_b", 0, 0, 0);
        step();
        chk_b("r_first_b", 1, 0, 0);
        chk_a("r_first_a", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the 8-bit free-running counter: configurable width, modulus and tick prescaler.
- Up/down counting, synchronous parallel load, and wrap or saturate mode.
- Registered terminal-count pulse and a sticky done flag.
- Serves as the general timebase/event counter for the design; cascadable via `tc`.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, upper count bound; counts span 0..MAX_VAL; must be < 2**WIDTH and >=1.
- PRESCALE, 1, enabled non-paused cycles per count tick (>=1); 1 = tick every cycle.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  count enable; low forces counter/prescaler/done to 0.
- pause  in  1  hold: freezes count and prescaler.
- dir  in  1  1 = up, 0 = down; sampled at each tick.
- sat_mode  in  1  0 = wrap at bound, 1 = saturate at bound.
- load  in  1  synchronous load strobe.
- load_data  in  WIDTH  load value; values > MAX_VAL clamp to MAX_VAL.
- cnt_data  out  WIDTH  current count (registered).
- tc  out  1  one-cycle terminal-count pulse (registered).
- done  out  1  sticky: saturate-mode bound reached.

Behaviour:
- Single clock domain, clk. Reset is asynchronous, active-low (rst_n); deassertion is synchronous to clk upstream.
- Reset values: cnt_data=0, tc=0, done=0, prescaler count=0.
- Per-edge priority, highest first:
  - load: cnt_data<=clamp(load_data); prescaler<=0; done<=0; tc<=0. Load is honoured even when cnt_en=0 or pause=1.
  - !cnt_en: cnt_data<=0; prescaler<=0; done<=0; tc<=0.
  - pause: all state held; tc<=0.
  - Otherwise active: prescaler advances.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 on active cycles.
  - tick = active && pre_cnt==PRESCALE-1 (combinational); pre_cnt wraps to 0 on tick.
  - PRESCALE=1: tick on every active cycle, pre_cnt constant 0.
- Bound: MAX_VAL when dir=1, 0 when dir=0. A dir change mid-run takes effect at the next tick; the prescaler is not reset.
- On tick with cnt_data != bound: cnt_data +/- 1; tc<=0.
- On tick with cnt_data == bound, sat_mode=0 (wrap):
  - cnt_data <= opposite end (0 when up, MAX_VAL when down).
  - tc<=1 for exactly that edge.
- On tick with cnt_data == bound, sat_mode=1 (saturate):
  - If done=0: cnt_data held, done<=1, tc<=1 once.
  - If done=1: no change, tc<=0.
  - done clears only on load, !cnt_en or reset. Changing dir while done=1 does not restart counting until done is cleared.
- sat_mode switched 1->0 while done=1: done stays set and counting remains halted until cleared. This is intentional; the bench must check it.
- Non-power-of-two MAX_VAL: the count never exceeds MAX_VAL. Arithmetic is WIDTH-bit with explicit bound compare, never relying on natural overflow.
- Latency: first increment lands on the first rising edge with rst_n=1, cnt_en=1, pause=0 (PRESCALE=1). tc is high in the same cycle cnt_data shows the wrapped value.
- Reset mid-operation: all outputs go to reset values immediately, independent of clk.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Function clog2 for sizing the prescaler count.
- One sub-module, tick_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst_n, clr, en, tick.
  - clr = load | !cnt_en; en = cnt_en & !pause.
- Counter datapath, bound compare and flags stay in mod_updown_counter.

Test Plan:
- Reset/basic (WIDTH=8, defaults): rst_n low 100 ns, then cnt_en=1, dir=1 -> cnt_data 0,1,2,... per cycle; 255 -> 0 with tc=1 for one cycle; tc=0 otherwise.
- Modulus + down (WIDTH=4, MAX_VAL=9): count up 0..9 -> 0 with tc pulse. Set dir=0 at cnt_data=3 -> 2,1,0 -> 9 with tc pulse; cnt_data never reads 10..15.
- Prescaler + pause (PRESCALE=4): cnt_data increments every 4th cycle. pause=1 for 3 cycles mid-period -> value and phase held; the increment arrives exactly 3 cycles later than unpaused.
- Saturate (WIDTH=4, MAX_VAL=9, sat_mode=1): up to 9 -> tc once, done=1, cnt_data stays 9 for 20 further cycles. Load 5 -> cnt_data=5, done=0, counting resumes 6,7...
- Load priority/clamp (MAX_VAL=9): load=1 with load_data=12 while cnt_en=0 -> cnt_data=9. Load while pause=1 -> value loaded. cnt_en low -> cnt_data=0, done=0 next edge.
- Async reset mid-count: assert rst_n low between clock edges at cnt_data=7 -> cnt_data, tc, done go to 0 before the next edge; they stay 0 until rst_n high and an active edge.
